// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter: counting-mode encodings.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_BOUNCE  = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

endpackage

// File: rtl/tick_prescaler.sv
// Enable prescaler: counts enabled cycles 0..DIV-1 and strobes step on the last one.
module tick_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic step
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
    end
  end

  // A load on the same edge overrides the step.
  assign step = enable && !clear && (cnt_q == LAST);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, window bounds, prescaler and four counting modes.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] min_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             tick,
  output logic             carry,
  output logic             borrow,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;
  logic             step;

  assign err = (min_val > max_val);

  // An inverted window freezes the prescaler along with q and dir.
  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable && !err),
    .clear  (load),
    .step   (step)
  );

  always_comb begin
    q_d      = q_q;
    dir_d    = dir_q;
    done_d   = done_q;
    tick_d   = 1'b0;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (load) begin
      q_d    = (load_val >= min_val && load_val <= max_val) ? load_val : min_val;
      done_d = 1'b0;
      dir_d  = (mode_e'(mode) != MODE_DOWN);
    end else if (step) begin
      tick_d = 1'b1;
      unique case (mode_e'(mode))
        MODE_UP: begin
          dir_d = 1'b1;
          if (q_q >= max_val) begin
            q_d     = min_val;
            carry_d = 1'b1;
          end else begin
            q_d = q_q + ONE;
          end
        end
        MODE_DOWN: begin
          dir_d = 1'b0;
          if (q_q <= min_val || q_q > max_val) begin
            q_d      = max_val;
            borrow_d = 1'b1;
          end else begin
            q_d = q_q - ONE;
          end
        end
        MODE_BOUNCE: begin
          if (min_val == max_val) begin
            q_d = min_val;
          end else if (dir_q) begin
            if (q_q >= max_val) begin
              dir_d   = 1'b0;
              q_d     = max_val - ONE;
              carry_d = 1'b1;
            end else begin
              q_d = q_q + ONE;
            end
          end else begin
            if (q_q <= min_val) begin
              dir_d    = 1'b1;
              q_d      = min_val + ONE;
              borrow_d = 1'b1;
            end else begin
              q_d = q_q - ONE;
            end
          end
        end
        MODE_ONESHOT: begin
          dir_d = 1'b1;
          if (done_q) begin
            tick_d = 1'b0;
          end else if (q_q >= max_val) begin
            q_d     = max_val;
            done_d  = 1'b1;
            carry_d = 1'b1;
          end else begin
            q_d = q_q + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q      <= '0;
      dir_q    <= 1'b1;
      tick_q   <= 1'b0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      dir_q    <= dir_d;
      tick_q   <= tick_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

  assign q      = q_q;
  assign dir    = dir_q;
  assign tick   = tick_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;
  assign done   = done_q;

endmodule
